// File: rtl/ram_test_pkg.sv
// Shared types and the data-pattern generator for the RAM march tester.
package ram_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        PAT_ADDR,
        PAT_INV,
        PAT_CHECKER,
        PAT_WALK
    } pattern_t;

    localparam int unsigned PAT_MAX_W = 64;

    // Result is PAT_MAX_W wide; callers truncate to their data width (dw <= 64).
    function automatic logic [PAT_MAX_W-1:0] pat(input pattern_t p, input logic [31:0] a,
                                                 input int unsigned dw);
        logic [PAT_MAX_W-1:0] r;
        case (p)
            PAT_ADDR:    r = {32'd0, a};
            PAT_INV:     r = ~{32'd0, a};
            PAT_CHECKER: r = a[0] ? {32{2'b10}} : {32{2'b01}};
            default:     r = 64'd1 << (a % dw);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ram_expect_pipe.sv
// RD_LAT-deep delay line carrying read-valid, address and expected data
// so each compare lines up with the RAM's returned word.
module ram_expect_pipe #(
    parameter int ADR_W  = 14,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [ADR_W-1:0]  in_adr,
    input  logic [DATA_W-1:0] in_exp,
    output logic              out_vld,
    output logic [ADR_W-1:0]  out_adr,
    output logic [DATA_W-1:0] out_exp
);

    logic [RD_LAT:1]             vld_pipe;
    logic [RD_LAT:1][ADR_W-1:0]  adr_pipe;
    logic [RD_LAT:1][DATA_W-1:0] exp_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            adr_pipe <= '0;
            exp_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_vld;
            adr_pipe[1] <= in_adr;
            exp_pipe[1] <= in_exp;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                adr_pipe[i] <= adr_pipe[i-1];
                exp_pipe[i] <= exp_pipe[i-1];
            end
        end
    end

    assign out_vld = vld_pipe[RD_LAT];
    assign out_adr = adr_pipe[RD_LAT];
    assign out_exp = exp_pipe[RD_LAT];

endmodule

// File: rtl/ram_march_tester.sv
// Write-then-read RAM sweep tester: fills every word with a selectable
// pattern, reads it back and records mismatch count and first failing address.
module ram_march_tester
    import ram_test_pkg::*;
#(
    parameter int ADR_W  = 14,
    parameter int DATA_W = 8,
    parameter int ERR_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        pattern,
    input  logic              all_clear,
    output logic              busy,
    output logic              done,
    output logic [ADR_W-1:0]  ram_adr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_data_out,
    input  logic [DATA_W-1:0] ram_data_in,
    output logic [ERR_W-1:0]  err_count,
    output logic              first_err_valid,
    output logic [ADR_W-1:0]  first_err_adr
);

    localparam logic [ADR_W-1:0] ADR_MAX    = '1;
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;
    localparam logic [1:0]       DRAIN_LAST = 2'(RD_LAT - 1);

    state_t              state, state_nxt;
    pattern_t            pat_q;
    logic [ADR_W-1:0]    adr;
    logic [1:0]          drain_cnt;
    logic [DATA_W-1:0]   exp_data;
    logic                start_acc;
    logic                cmp_vld;
    logic [ADR_W-1:0]    cmp_adr;
    logic [DATA_W-1:0]   cmp_exp;
    logic                mismatch;

    assign start_acc = (state == ST_IDLE) && start;
    assign exp_data  = DATA_W'(pat(pat_q, 32'(adr), DATA_W));
    assign mismatch  = cmp_vld && (ram_data_in != cmp_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_WRITE;
            ST_WRITE: if (adr == ADR_MAX) state_nxt = ST_READ;
            ST_READ:  if (adr == ADR_MAX) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != ST_IDLE);
        done         = (state == ST_DONE);
        ram_we       = (state == ST_WRITE);
        ram_adr      = adr;
        ram_data_out = '0;
        if (state == ST_WRITE) ram_data_out = exp_data;
    end

    // Address wraps naturally from ADR_MAX to 0 between WRITE and READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr       <= '0;
            pat_q     <= PAT_ADDR;
            drain_cnt <= '0;
        end else begin
            if (start_acc) pat_q <= pattern_t'(pattern);
            if (state == ST_WRITE || state == ST_READ) adr <= adr + 1'b1;
            else                                       adr <= '0;
            if (state == ST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
            else                   drain_cnt <= '0;
        end
    end

    // Clear (explicit or by a new pass) takes priority over a same-cycle mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_adr   <= '0;
        end else if (all_clear || start_acc) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_adr   <= '0;
        end else if (mismatch) begin
            if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
            if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_adr   <= cmp_adr;
            end
        end
    end

    ram_expect_pipe #(
        .ADR_W  (ADR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_expect_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (state == ST_READ),
        .in_adr  (adr),
        .in_exp  (exp_data),
        .out_vld (cmp_vld),
        .out_adr (cmp_adr),
        .out_exp (cmp_exp)
    );

endmodule

// File: tb/tb_ram_march_tester.sv
// Bench for ram_march_tester: two instances (RD_LAT=1/ERR_W=3 and RD_LAT=3)
// against behavioural RAMs with injectable stuck-at and all-zero faults.
module tb_ram_march_tester;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start1 = 1'b0, start3 = 1'b0;
    logic       all_clear1 = 1'b0, all_clear3 = 1'b0;
    logic [1:0] pattern = 2'd0;

    logic       busy1, done1, we1, fev1;
    logic [3:0] adr1, fea1;
    logic [7:0] dout1, din1;
    logic [2:0] err1;

    logic       busy3, done3, we3, fev3;
    logic [3:0] adr3, fea3;
    logic [7:0] dout3, din3;
    logic [15:0] err3;

    ram_march_tester #(.ADR_W(4), .DATA_W(8), .ERR_W(3), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .pattern(pattern), .all_clear(all_clear1),
        .busy(busy1), .done(done1), .ram_adr(adr1), .ram_we(we1), .ram_data_out(dout1),
        .ram_data_in(din1), .err_count(err1), .first_err_valid(fev1), .first_err_adr(fea1));

    ram_march_tester #(.ADR_W(4), .DATA_W(8), .ERR_W(16), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .pattern(pattern), .all_clear(all_clear3),
        .busy(busy3), .done(done3), .ram_adr(adr3), .ram_we(we3), .ram_data_out(dout3),
        .ram_data_in(din3), .err_count(err3), .first_err_valid(fev3), .first_err_adr(fea3));

    // RAM models with fault injection on the read path
    logic       zero_mode = 1'b0;
    logic [3:0] flt_adr = 4'd0;
    logic [7:0] flt_mask = 8'd0;
    logic [7:0] mem1 [16];
    logic [7:0] mem3 [16];
    logic [7:0] rd1, rd3_a, rd3_b, rd3_c;

    function automatic logic [7:0] ram_rd(logic [7:0] m, logic [3:0] a);
        if (zero_mode) return 8'h00;
        return (a == flt_adr) ? (m & ~flt_mask) : m;
    endfunction

    always @(posedge clk) begin
        if (we1) mem1[adr1] <= dout1;
        rd1 <= ram_rd(mem1[adr1], adr1);
        if (we3) mem3[adr3] <= dout3;
        rd3_a <= ram_rd(mem3[adr3], adr3);
        rd3_b <= rd3_a;
        rd3_c <= rd3_b;
    end
    assign din1 = rd1;
    assign din3 = rd3_c;

    bit          sel = 1'b0;
    logic        cur_busy, cur_done, cur_we, cur_fev;
    logic [3:0]  cur_adr, cur_fea;
    logic [7:0]  cur_dout;
    logic [15:0] cur_err;

    always_comb begin
        cur_busy = sel ? busy3 : busy1;
        cur_done = sel ? done3 : done1;
        cur_we   = sel ? we3 : we1;
        cur_fev  = sel ? fev3 : fev1;
        cur_adr  = sel ? adr3 : adr1;
        cur_fea  = sel ? fea3 : fea1;
        cur_dout = sel ? dout3 : dout1;
        cur_err  = sel ? err3 : {13'd0, err1};
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] tb_pat(logic [1:0] p, logic [3:0] a);
        case (p)
            2'd0:    return {4'h0, a};
            2'd1:    return ~{4'h0, a};
            2'd2:    return a[0] ? 8'hAA : 8'h55;
            default: return 8'h01 << a[2:0];
        endcase
    endfunction

    typedef struct {
        bit         sel;
        logic [1:0] pat;
        bit         zero;
        logic [3:0] fadr;
        logic [7:0] fmask;
        int         err;
        bit         fev;
        logic [3:0] fea;
        int         cyc;
        int         rdc;
    } vec_t;

    vec_t vecs [8];
    vec_t sb [$];

    task automatic set_start(bit s, logic v);
        if (s) start3 = v;
        else   start1 = v;
    endtask

    task automatic run_vec(vec_t v, string tag);
        int n, wr, wrbad, rdc;
        bit seen;
        vec_t e;
        n = 1; wr = 0; wrbad = 0; rdc = 0; seen = 0;
        @(negedge clk);
        sel = v.sel; pattern = v.pat; zero_mode = v.zero; flt_adr = v.fadr; flt_mask = v.fmask;
        set_start(v.sel, 1'b1);
        sb.push_back(v);
        @(negedge clk);
        set_start(v.sel, 1'b0);
        while (!seen && n <= 200) begin
            if (cur_we) begin
                if (cur_adr != 4'(wr) || cur_dout != tb_pat(v.pat, cur_adr)) wrbad++;
                wr++;
            end else if (cur_busy && !cur_done) rdc++;
            if (cur_done) seen = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL %s_timeout: no done within 200 cycles", tag);
        end
        e = sb.pop_front();
        chk({tag, "_cycles"}, n, e.cyc);
        chk({tag, "_writes"}, wr, 16);
        chk({tag, "_wr_bad"}, wrbad, 0);
        chk({tag, "_rd_drain"}, rdc, e.rdc);
        chk({tag, "_err"}, int'(cur_err), e.err);
        chk({tag, "_fev"}, int'(cur_fev), int'(e.fev));
        chk({tag, "_fea"}, int'(cur_fea), int'(e.fea));
        @(negedge clk);
        chk({tag, "_hold_err"}, int'(cur_err), e.err);
        chk({tag, "_idle_busy"}, int'(cur_busy), 0);
    endtask

    task automatic chk_reset1(string tag);
        chk({tag, "_busy"}, int'(busy1), 0);
        chk({tag, "_done"}, int'(done1), 0);
        chk({tag, "_we"}, int'(we1), 0);
        chk({tag, "_adr"}, int'(adr1), 0);
        chk({tag, "_dout"}, int'(dout1), 0);
        chk({tag, "_err"}, int'(err1), 0);
        chk({tag, "_fev"}, int'(fev1), 0);
        chk({tag, "_fea"}, int'(fea1), 0);
    endtask

    initial begin
        int dones, done_n;
        //        sel pat zero fadr  fmask  err fev fea   cyc rdc
        vecs[0] = '{0, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 34, 17};
        vecs[1] = '{0, 3, 0, 4'h2, 8'h04, 1, 1, 4'h2, 34, 17};
        vecs[2] = '{0, 1, 1, 4'h0, 8'h00, 7, 1, 4'h0, 34, 17};
        vecs[3] = '{0, 2, 0, 4'h0, 8'h00, 0, 0, 4'h0, 34, 17};
        vecs[4] = '{0, 0, 0, 4'hC, 8'h08, 1, 1, 4'hC, 34, 17};
        vecs[5] = '{1, 2, 0, 4'h0, 8'h00, 0, 0, 4'h0, 36, 19};
        vecs[6] = '{1, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 36, 19};
        vecs[7] = '{1, 3, 0, 4'h7, 8'h80, 1, 1, 4'h7, 36, 19};

        #2;
        chk_reset1("rst1");
        chk("rst3_busy", int'(busy3), 0);
        chk("rst3_err", int'(err3), 0);
        chk("rst3_adr", int'(adr3), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Saturated result from v7's predecessor is gone; check all_clear in IDLE on dut1.
        run_vec(vecs[2], "sat");
        all_clear1 = 1'b1;
        @(negedge clk);
        all_clear1 = 1'b0;
        chk("idle_clear_err", int'(err1), 0);
        chk("idle_clear_fev", int'(fev1), 0);

        // start during READ ignored; all_clear during a mismatch compare wins
        sel = 0; pattern = 2'd1; zero_mode = 1'b1; flt_mask = 8'h00;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        dones = 0; done_n = 0;
        for (int n = 1; n <= 80; n++) begin
            if (done1) begin
                dones++;
                if (dones == 1) begin
                    done_n = n;
                    chk("mid_final_err", int'(err1), 7);
                    chk("mid_final_fev", int'(fev1), 1);
                    chk("mid_final_fea", int'(fea1), 7);
                end
            end
            start1 = (n == 20);
            if (n == 24) begin
                chk("mid_pre_clear", int'(err1), 6);
                all_clear1 = 1'b1;
            end else all_clear1 = 1'b0;
            if (n == 25) begin
                chk("mid_clear_wins_err", int'(err1), 0);
                chk("mid_clear_wins_fev", int'(fev1), 0);
            end
            @(negedge clk);
        end
        chk("mid_single_done", dones, 1);
        chk("mid_done_cycle", done_n, 34);

        // reset mid-READ flushes in-flight compares
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("flush_rst_err", int'(err1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("flush_err", int'(err1), 0);
        chk("flush_fev", int'(fev1), 0);
        chk("flush_busy", int'(busy1), 0);

        // reset mid-WRITE at address 7, then a clean pass
        zero_mode = 1'b0; pattern = 2'd0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (7) @(negedge clk);
        chk("wr7_adr", int'(adr1), 7);
        chk("wr7_we", int'(we1), 1);
        rst_n = 1'b0;
        #1;
        chk_reset1("wr7_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
